// File: rtl/sd_pkg.sv
// Shared constants, state and error encodings for the SD block receive path.
package sd_pkg;

    localparam logic [7:0] SD_TOKEN_START  = 8'hFE;
    localparam logic [7:0] SD_BYTE_IDLE    = 8'hFF;
    localparam int         SD_SECTOR_BYTES = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_DONE
    } sd_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_TOKEN   = 2'd2
    } sd_err_e;

    // Wire order is MSB first; the buffer stores the first wire bit lowest.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            r[j] = b[7-j];
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_sector_assembler.sv
// Receives one SD data block (token, 512 bytes, CRC) into a 4096-bit
// sector buffer, flagging token timeout or an error token.
module sd_sector_assembler
    import sd_pkg::*;
#(
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [7:0]                      rx_byte,
    input  logic                            rx_valid,
    output logic                            xfer_req,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [1:0]                      err_code,
    output logic [SD_SECTOR_BYTES*8-1:0]    sector_data
);

    localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
    localparam logic [TW-1:0] TOK_LAST = TW'(TOKEN_TIMEOUT - 1);

    sd_state_e                       r_state;
    logic [8:0]                      r_byte_cnt;
    logic                            r_crc_cnt;
    logic [TW-1:0]                   r_tok_cnt;
    logic                            r_xfer_req;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_err;
    logic [1:0]                      r_err_code;
    logic [SD_SECTOR_BYTES*8-1:0]    r_sector;

    logic                            w_we;
    logic [7:0]                      w_byte_rev;

    assign w_we       = (r_state == ST_DATA) && rx_valid;
    assign w_byte_rev = bit_rev8(rx_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_crc_cnt  <= 1'b0;
            r_tok_cnt  <= '0;
            r_xfer_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_WAIT_TOKEN;
                        r_tok_cnt  <= '0;
                        r_err_code <= ERR_NONE;
                        r_xfer_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_WAIT_TOKEN: begin
                    if (rx_valid) begin
                        if (rx_byte == SD_TOKEN_START) begin
                            r_state    <= ST_DATA;
                            r_byte_cnt <= '0;
                        end else if (rx_byte == SD_BYTE_IDLE) begin
                            if (r_tok_cnt == TOK_LAST) begin
                                r_state    <= ST_IDLE;
                                r_err      <= 1'b1;
                                r_err_code <= ERR_TIMEOUT;
                                r_xfer_req <= 1'b0;
                                r_busy     <= 1'b0;
                            end else begin
                                r_tok_cnt <= r_tok_cnt + 1'b1;
                            end
                        end else begin
                            r_state    <= ST_IDLE;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_TOKEN;
                            r_xfer_req <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 9'(SD_SECTOR_BYTES - 1)) begin
                            r_state   <= ST_CRC;
                            r_crc_cnt <= 1'b0;
                        end
                    end
                end
                ST_CRC: begin
                    if (rx_valid) begin
                        r_crc_cnt <= ~r_crc_cnt;
                        if (r_crc_cnt) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_xfer_req <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_xfer_req <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Per-byte write enable decoded from the byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sector <= '0;
        end else begin
            for (int k = 0; k < SD_SECTOR_BYTES; k++) begin
                if (w_we && (r_byte_cnt == 9'(k))) begin
                    r_sector[8*k +: 8] <= w_byte_rev;
                end
            end
        end
    end

    assign xfer_req    = r_xfer_req;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign sector_data = r_sector;

endmodule

// File: tb/tb_sd_sector_assembler.sv
// Scoreboard bench for sd_sector_assembler: randomized block traffic
// checked against a byte-array model of the sector.
module tb_sd_sector_assembler;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic          xfer_req;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [4095:0] sector_data;

    sd_sector_assembler #(.TOKEN_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .xfer_req   (xfer_req),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .sector_data(sector_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [1:0]    code;
        logic [4095:0] data;
    } exp_t;

    exp_t     q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    int       n_done = 0;
    int       n_errp = 0;
    bit [7:0] model_mem[512];
    bit [7:0] blk[512];

    function automatic logic [4095:0] build(input bit [7:0] m[512]);
        logic [4095:0] v;
        for (int k = 0; k < 512; k++)
            for (int j = 0; j < 8; j++)
                v[8*k+j] = m[k][7-j];
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [4095:0] s,
                                            input int w);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[31-i] = s[32*w+i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_sector(input string name,
                                input logic [4095:0] exp);
        n_chk++;
        if (sector_data !== exp) begin
            n_fail++;
            for (int k = 0; k < 512; k++) begin
                if (sector_data[8*k +: 8] !== exp[8*k +: 8]) begin
                    $display("FAIL %s: byte slot %0d got %h expected %h",
                             name, k, sector_data[8*k +: 8],
                             exp[8*k +: 8]);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            exp_t e;
            if (done) n_done++;
            if (err) n_errp++;
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b expected none",
                         done, err);
            end else begin
                e = q.pop_front();
                if ({done, err} !== {!e.is_err, e.is_err}) begin
                    n_fail++;
                    $display("FAIL pulse_kind: done=%0b err=%0b expected err=%0b",
                             done, err, e.is_err);
                end else if (e.is_err) begin
                    check("err_code_at_pulse", 64'(err_code), 64'(e.code));
                end else begin
                    check_sector("sector_at_done", e.data);
                end
            end
        end
    end

    task automatic beat(input bit v, input logic [7:0] b, input bit st);
        rx_valid = v;
        rx_byte  = b;
        start    = st;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit st);
        while ($urandom_range(0, 99) < gap)
            beat(1'b0, 8'($urandom), 1'b0);
        beat(1'b1, b, st);
    endtask

    task automatic pulse_start(input bit stray);
        beat(stray, 8'hFE, 1'b1);
        check("busy_after_start", 64'(busy), 64'd1);
        check("xfer_after_start", 64'(xfer_req), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("idle_within_budget", 64'(busy), 64'd0);
    endtask

    // Streams blk[] as one block; fast leaves one idle beat then returns.
    task automatic run_block(input int n_ff, input int gap,
                             input bit mid_start, input bit stray,
                             input bit part_chk, input bit fast);
        exp_t     e;
        bit [7:0] tmp[512];
        logic [4095:0] part;
        tmp = model_mem;
        for (int k = 0; k < 4; k++) tmp[k] = blk[k];
        part = build(tmp);
        model_mem = blk;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.data   = build(model_mem);
        q.push_back(e);
        pulse_start(stray);
        check("err_code_cleared", 64'(err_code), 64'd0);
        repeat (n_ff) send(8'hFF, gap, 1'b0);
        send(8'hFE, gap, 1'b0);
        for (int k = 0; k < 512; k++) begin
            send(blk[k], gap, mid_start && k == 100);
            if (part_chk && k == 3)
                check_sector("old_data_held", part);
        end
        send(8'($urandom), gap, 1'b0);
        send(8'($urandom), gap, 1'b0);
        check("xfer_in_done", 64'(xfer_req), 64'd0);
        check("busy_in_done", 64'(busy), 64'd1);
        if (fast) begin
            beat(1'b0, 8'h00, 1'b0);
            check("idle_after_done", 64'(busy), 64'd0);
        end else begin
            wait_idle(50);
        end
    endtask

    initial begin
        exp_t e;
        for (int k = 0; k < 512; k++) model_mem[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_xfer", 64'(xfer_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check_sector("rst_sector", build(model_mem));
        rst = 1'b0;
        beat(1'b0, 8'h00, 1'b0);

        // Incrementing pattern, no gaps.
        for (int k = 0; k < 512; k++) blk[k] = 8'(k);
        run_block(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("word0", 64'(word_of(sector_data, 0)), 64'h00010203);
        check("word127", 64'(word_of(sector_data, 127)), 64'hFCFDFEFF);
        check("err_code_ok", 64'(err_code), 64'd0);

        // Token timeout after 8 idle bytes.
        pulse_start(1'b0);
        repeat (7) send(8'hFF, 0, 1'b0);
        check("busy_before_timeout", 64'(busy), 64'd1);
        e.is_err = 1'b1;
        e.code   = 2'd1;
        e.data   = '0;
        q.push_back(e);
        send(8'hFF, 0, 1'b0);
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_busy", 64'(busy), 64'd0);
        check("timeout_code", 64'(err_code), 64'd1);
        beat(1'b0, 8'h00, 1'b0);
        check("err_one_cycle", 64'(err), 64'd0);

        // Error token.
        pulse_start(1'b0);
        check("code_cleared_on_start", 64'(err_code), 64'd0);
        send(8'hFF, 0, 1'b0);
        e.code = 2'd2;
        q.push_back(e);
        send(8'h05, 0, 1'b0);
        check("errtok_code", 64'(err_code), 64'd2);
        beat(1'b0, 8'h00, 1'b0);
        check("errtok_xfer_low", 64'(xfer_req), 64'd0);
        check("errtok_code_held", 64'(err_code), 64'd2);

        // Reset in the middle of the payload.
        pulse_start(1'b0);
        send(8'hFE, 0, 1'b0);
        for (int k = 0; k < 200; k++) send(8'($urandom), 0, 1'b0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 512; k++) model_mem[k] = 8'h00;
        check_sector("sector_cleared_by_rst", build(model_mem));
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 512; k++) blk[k] = 8'hA5;
        run_block(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Gapped stream, stray byte with start, start pulse mid-payload.
        for (int k = 0; k < 512; k++) blk[k] = 8'(k);
        run_block(2, 30, 1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back random blocks.
        for (int k = 0; k < 512; k++) blk[k] = 8'($urandom);
        run_block(1, 10, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 512; k++) blk[k] = 8'($urandom);
        run_block(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) beat(1'b0, 8'h00, 1'b0);
        check("queue_drained", 64'(q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'd5);
        check("err_count", 64'(n_errp), 64'd2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
